event_recorder: RTL and testbench
=================================

# event_recorder

Captures one record per trigger into an on-chip event FIFO for later readout. Sits downstream of `TRIGGER_HANDLER`: it consumes `TRIGGER_OUT` (`TRIGGER_ACTIVE`) together with the `TOT_SHORT` and `TOT_LONG` values from the two `TOT_CALCULATOR` instances, all in the `CLK_FAST` domain. Each record holds a timestamp and both TOT values. Records are popped one at a time by the control/readout logic, and trigger and drop statistics are maintained.

## Interface
Parameters:
- `ADDR_W`, 8: FIFO depth is 2^ADDR_W records (256).
- `TS_W`, 32: timestamp width.

Ports:
- `CLK` in 1: fast acquisition clock (`CLK_FAST`).
- `RESET` in 1: asynchronous, active-high; one clock, no other clock domains.
- `TRIGGER_IN` in 1: trigger active level from the trigger handler.
- `TOT_SHORT` in 16: short-window TOT sum.
- `TOT_LONG` in 16: long-window TOT sum.
- `read_mode` in 1: high freezes capture (buffer readout window).
- `CLEAR` in 1: synchronous flush of FIFO and counters.
- `RD_POP` in 1: single-cycle pop request.
- `RD_VALID` out 1: one-cycle strobe, `RD_DATA` valid.
- `RD_DATA` out TS_W+32: record `{timestamp, TOT_SHORT, TOT_LONG}`, MSB first.
- `COUNT` out ADDR_W+1: records currently stored.
- `EMPTY` out 1, `FULL` out 1: FIFO status.
- `NTRIGGERS` out 32: accepted trigger edges.
- `NDROPPED` out 16: edges lost because the FIFO was full, saturating.

## Operation
- Free-running timestamp counter `TS`, TS_W bits, increments every cycle, wraps to 0.
- Edge detect: `trig_d <= TRIGGER_IN`; strobe = `TRIGGER_IN & ~trig_d`.
- On a strobe with `read_mode=0`, the record `{TS, TOT_SHORT, TOT_LONG}` is sampled in the same cycle as the strobe.
  - If not FULL: write at `wr_ptr`, increment `wr_ptr`, increment `NTRIGGERS`.
  - If FULL: no write; `NDROPPED` increments, saturating at 16'hFFFF. `NTRIGGERS` still increments.
- Strobe with `read_mode=1`: ignored entirely; no counters change.
- Read FSM has three states:
  - IDLE: `RD_POP` and not EMPTY → issue RAM read at `rd_ptr`, go to FETCH.
  - FETCH: RAM output registered → go to PRESENT.
  - PRESENT: `RD_VALID=1` for one cycle, increment `rd_ptr`, `COUNT` decrements → IDLE.
- `RD_POP` outside IDLE, or while EMPTY, is ignored; `RD_DATA` holds its last value.
- Pointers are ADDR_W bits and wrap modulo depth. `COUNT` is a separate ADDR_W+1-bit counter. FULL = (`COUNT` == 2^ADDR_W); EMPTY = (`COUNT` == 0).
- Write and PRESENT in the same cycle: `COUNT` is unchanged, and both pointers advance. If FULL, the write is still dropped, because FULL is evaluated before the pop.
- `CLEAR` has priority over all activity:
  - Pointers, `COUNT`, `NTRIGGERS`, `NDROPPED` go to 0; FSM goes to IDLE; `RD_VALID` goes to 0.
  - `TS` is not cleared.
  - RAM contents are untouched.

## Timing
- Reset values: `RD_VALID=0`, `RD_DATA=0`, `COUNT=0`, `EMPTY=1`, `FULL=0`, `NTRIGGERS=0`, `NDROPPED=0`, `TS=0`, `trig_d=0`, FSM in IDLE.
- Capture latency: a rising edge of `TRIGGER_IN` sampled at cycle N produces a strobe in cycle N. The write happens at the end of cycle N, and the record carries `TS` and TOT values from cycle N.
- `COUNT`, `EMPTY` and `FULL` update in cycle N+1.
- Read latency: `RD_POP` sampled at cycle M → `RD_VALID` high in cycle M+2 exactly. Sustained throughput is one record per 3 cycles.
- Minimum trigger spacing is 2 cycles (high, low, high); every such edge is recorded.
- Reset mid-read aborts the read: no `RD_VALID`, and the record's `rd_ptr` is lost because the pointers return to 0.

## Structure
- Shared package `event_recorder_pkg` holds:
  - record field offsets/widths (`TS_MSB`, `TOTS_MSB`, `TOTL_MSB`);
  - `REC_W = TS_W + 32`;
  - FSM state encodings (IDLE=2'd0, FETCH=2'd1, PRESENT=2'd2).
- Sub-module `event_ram`: simple dual-port memory, 2^ADDR_W × REC_W.
  - Registered read, write-first not required.
  - Maps to four SB_RAM40_4K blocks (256×16) for defaults.

## Test plan
- Reset, then one trigger pulse (3 cycles high) at `TS=100` with `TOT_SHORT=0x0012`, `TOT_LONG=0x0345`, then pop → `RD_VALID` 2 cycles after pop; `RD_DATA={32'd100, 16'h0012, 16'h0345}`; `NTRIGGERS=1`; `EMPTY=1` afterwards.
- 260 triggers spaced 2 cycles apart, no pops → `COUNT=256`, `FULL=1`, `NTRIGGERS=260`, `NDROPPED=4`. The first pop returns the first record.
- Trigger strobe in the same cycle as PRESENT with `COUNT=5` → `COUNT` stays 5; the popped record is the oldest one; the new record lands at the tail.
- `read_mode=1` during 10 trigger edges → `COUNT`, `NTRIGGERS` and `NDROPPED` unchanged. `read_mode=0` followed by an edge → `COUNT` +1.
- Fill with 3 records, pulse `CLEAR` during FETCH → no `RD_VALID`; `COUNT=0`; `EMPTY=1`; counters 0; `TS` keeps counting.
- Preload `TS` near wrap (force to 0xFFFFFFFE), trigger twice 2 cycles apart → timestamps 0xFFFFFFFE and 0x00000000 read back in order.

Source files
------------

// File: rtl/event_recorder_pkg.sv
// Shared definitions for the event recorder: record layout and read FSM encoding.
package event_recorder_pkg;

  localparam int unsigned TOT_W    = 16;
  localparam int unsigned DEF_TS_W = 32;
  localparam int unsigned REC_W    = DEF_TS_W + 2 * TOT_W;

  // Record is {timestamp, tot_short, tot_long}, MSB first
  localparam int unsigned TS_MSB   = REC_W - 1;
  localparam int unsigned TOTS_MSB = 2 * TOT_W - 1;
  localparam int unsigned TOTL_MSB = TOT_W - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } rd_state_e;

endpackage

// File: rtl/event_ram.sv
// Simple dual-port record memory with a registered read port.
module event_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Memory array carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/event_recorder.sv
// Captures {timestamp, TOT_SHORT, TOT_LONG} on each trigger rising edge into a FIFO
// and serves records one at a time through a three-state registered read path.
module event_recorder
  import event_recorder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TS_W   = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    TRIGGER_IN,
  input  logic [TOT_W-1:0]        TOT_SHORT,
  input  logic [TOT_W-1:0]        TOT_LONG,
  input  logic                    read_mode,
  input  logic                    CLEAR,
  input  logic                    RD_POP,
  output logic                    RD_VALID,
  output logic [TS_W+2*TOT_W-1:0] RD_DATA,
  output logic [ADDR_W:0]         COUNT,
  output logic                    EMPTY,
  output logic                    FULL,
  output logic [31:0]             NTRIGGERS,
  output logic [15:0]             NDROPPED
);

  localparam int unsigned   REC_BITS = TS_W + 2 * TOT_W;
  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};

  logic [TS_W-1:0]     ts_q, ts_d;
  logic                trig_q, trig_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic [31:0]         ntrig_q, ntrig_d;
  logic [15:0]         ndrop_q, ndrop_d;
  rd_state_e           state_q, state_d;
  logic                rd_valid_q, rd_valid_d;
  logic [REC_BITS-1:0] rd_data_q, rd_data_d;

  logic                strobe, accept, wr_en, pop, ram_re;
  logic [REC_BITS-1:0] ram_rdata;

  assign strobe = TRIGGER_IN & ~trig_q;
  assign accept = strobe & ~read_mode & ~CLEAR;
  assign wr_en  = accept & ~full_q;
  assign pop    = (state_q == PRESENT) & ~CLEAR;

  // FIFO bookkeeping and statistics; FULL is judged before a same-cycle pop
  always_comb begin
    ts_d     = ts_q + TS_W'(1);
    trig_d   = TRIGGER_IN;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ntrig_d  = ntrig_q;
    ndrop_d  = ndrop_q;
    if (CLEAR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ntrig_d  = '0;
      ndrop_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (wr_en && !pop)      count_d = count_q + (ADDR_W+1)'(1);
      else if (!wr_en && pop) count_d = count_q - (ADDR_W+1)'(1);
      if (accept) ntrig_d = ntrig_q + 32'd1;
      if (accept && full_q && (ndrop_q != 16'hFFFF)) ndrop_d = ndrop_q + 16'd1;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH);
  end

  // Read FSM: IDLE issues the RAM read, FETCH latches it, PRESENT strobes it out
  always_comb begin
    state_d    = state_q;
    ram_re     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (RD_POP && !empty_q) begin
          ram_re  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rd_data_d  = ram_rdata;
        rd_valid_d = 1'b1;
        state_d    = PRESENT;
      end
      PRESENT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (CLEAR) begin
      state_d    = IDLE;
      ram_re     = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ts_q       <= '0;
      trig_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ntrig_q    <= '0;
      ndrop_q    <= '0;
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      ts_q       <= ts_d;
      trig_q     <= trig_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ntrig_q    <= ntrig_d;
      ndrop_q    <= ndrop_d;
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  event_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (REC_BITS)
  ) u_ram (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({ts_q, TOT_SHORT, TOT_LONG}),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_data_q;
  assign COUNT     = count_q;
  assign EMPTY     = empty_q;
  assign FULL      = full_q;
  assign NTRIGGERS = ntrig_q;
  assign NDROPPED  = ndrop_q;

endmodule

// File: tb/tb_event_recorder.sv
// Directed bench for event_recorder: capture, readout, overflow, concurrency, clear, wrap.
module tb_event_recorder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        trig, rmode, clr, pop;
  logic [15:0] tot_s, tot_l;
  logic        rd_valid, empty, full;
  logic [63:0] rd_data;
  logic [8:0]  count;
  logic [31:0] ntrig;
  logic [15:0] ndrop;

  // Small instance (TS_W=3, depth 4) used for the timestamp wrap scenario
  logic        w_trig, w_pop;
  logic        w_valid, w_empty, w_full;
  logic [34:0] w_data;
  logic [2:0]  w_count;
  logic [31:0] w_ntrig;
  logic [15:0] w_ndrop;

  logic [31:0] m_ts;
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  // Reference timestamp: free-running from reset, never cleared
  always @(posedge CLK or posedge RESET) begin
    if (RESET) m_ts <= 32'd0;
    else       m_ts <= m_ts + 32'd1;
  end

  event_recorder dut (
    .CLK(CLK), .RESET(RESET), .TRIGGER_IN(trig), .TOT_SHORT(tot_s), .TOT_LONG(tot_l),
    .read_mode(rmode), .CLEAR(clr), .RD_POP(pop), .RD_VALID(rd_valid), .RD_DATA(rd_data),
    .COUNT(count), .EMPTY(empty), .FULL(full), .NTRIGGERS(ntrig), .NDROPPED(ndrop)
  );

  event_recorder #(.ADDR_W(2), .TS_W(3)) dut_w (
    .CLK(CLK), .RESET(RESET), .TRIGGER_IN(w_trig), .TOT_SHORT(16'h0BEE), .TOT_LONG(16'h0CAD),
    .read_mode(1'b0), .CLEAR(1'b0), .RD_POP(w_pop), .RD_VALID(w_valid), .RD_DATA(w_data),
    .COUNT(w_count), .EMPTY(w_empty), .FULL(w_full), .NTRIGGERS(w_ntrig), .NDROPPED(w_ndrop)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic edge_pulse(input logic [15:0] s, input logic [15:0] l, output logic [31:0] ts);
    trig = 1'b1; tot_s = s; tot_l = l; ts = m_ts;
    tick();
    trig = 1'b0;
    tick();
  endtask

  task automatic pop_rec(output logic v1, output logic v2, output logic [63:0] d);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    v1 = rd_valid;
    tick();
    v2 = rd_valid;
    d  = rd_data;
    tick();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; trig = 0; rmode = 0; clr = 0; pop = 0; tot_s = 0; tot_l = 0;
    w_trig = 0; w_pop = 0;
    repeat (3) tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    n_cmp++; if (count !== 9'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if ({empty, full} !== 2'b10) begin n_fail++; $display("FAIL reset_flags got %b want 10", {empty, full}); end
    n_cmp++; if ({ntrig, ndrop} !== 48'd0) begin n_fail++; $display("FAIL reset_stats got %h want 0", {ntrig, ndrop}); end
    RESET = 1'b0;
  endtask

  task automatic test_single();
    logic v1, v2;
    logic [63:0] d;
    int n = 0;
    while (m_ts != 32'd100 && n < 300) begin tick(); n++; end
    n_cmp++; if (m_ts !== 32'd100) begin n_fail++; $display("FAIL single_ts_wait got %0d want 100", m_ts); end
    trig = 1'b1; tot_s = 16'h0012; tot_l = 16'h0345;
    repeat (3) tick();
    trig = 1'b0;
    n_cmp++; if (count !== 9'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
    n_cmp++; if (ntrig !== 32'd1) begin n_fail++; $display("FAIL single_ntrig got %0d want 1", ntrig); end
    tick();
    pop_rec(v1, v2, d);
    n_cmp++; if ({v1, v2} !== 2'b01) begin n_fail++; $display("FAIL single_latency got %b want 01", {v1, v2}); end
    n_cmp++; if (d !== {32'd100, 16'h0012, 16'h0345}) begin n_fail++; $display("FAIL single_data got %h want %h", d, {32'd100, 16'h0012, 16'h0345}); end
    n_cmp++; if ({empty, count} !== {1'b1, 9'd0}) begin n_fail++; $display("FAIL single_empty got %b/%0d want 1/0", empty, count); end
    pop_rec(v1, v2, d);
    n_cmp++; if ({v1, v2} !== 2'b00) begin n_fail++; $display("FAIL empty_pop_valid got %b want 00", {v1, v2}); end
    n_cmp++; if (rd_data !== {32'd100, 16'h0012, 16'h0345}) begin n_fail++; $display("FAIL empty_pop_hold got %h", rd_data); end
  endtask

  task automatic test_overflow();
    logic [31:0] ts0, t;
    logic v1, v2;
    logic [63:0] d;
    do_clear();
    for (int i = 0; i < 260; i++) begin
      edge_pulse(16'(i), 16'(i) ^ 16'hFFFF, t);
      if (i == 0) ts0 = t;
    end
    n_cmp++; if (count !== 9'd256) begin n_fail++; $display("FAIL ovf_count got %0d want 256", count); end
    n_cmp++; if ({full, empty} !== 2'b10) begin n_fail++; $display("FAIL ovf_flags got %b want 10", {full, empty}); end
    n_cmp++; if (ntrig !== 32'd260) begin n_fail++; $display("FAIL ovf_ntrig got %0d want 260", ntrig); end
    n_cmp++; if (ndrop !== 16'd4) begin n_fail++; $display("FAIL ovf_ndrop got %0d want 4", ndrop); end
    pop_rec(v1, v2, d);
    n_cmp++; if (d !== {ts0, 16'h0000, 16'hFFFF} || v2 !== 1'b1) begin n_fail++; $display("FAIL ovf_first got %h/%b want %h/1", d, v2, {ts0, 16'h0000, 16'hFFFF}); end
    n_cmp++; if ({full, count} !== {1'b0, 9'd255}) begin n_fail++; $display("FAIL ovf_after_pop got %b/%0d want 0/255", full, count); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ex [6];
    logic [31:0] t;
    logic v1, v2;
    logic [63:0] d;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      edge_pulse(16'h1000 + 16'(i), 16'h2000 + 16'(i), t);
      ex[i] = {t, 16'h1000 + 16'(i), 16'h2000 + 16'(i)};
    end
    n_cmp++; if (count !== 9'd5) begin n_fail++; $display("FAIL b2b_pre_count got %0d want 5", count); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    tick();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== ex[0]) begin n_fail++; $display("FAIL b2b_oldest got %b/%h want 1/%h", rd_valid, rd_data, ex[0]); end
    trig = 1'b1; tot_s = 16'hAAAA; tot_l = 16'h5555;
    ex[5] = {m_ts, 16'hAAAA, 16'h5555};
    tick();
    trig = 1'b0;
    n_cmp++; if (count !== 9'd5) begin n_fail++; $display("FAIL b2b_count got %0d want 5", count); end
    n_cmp++; if (ntrig !== 32'd6) begin n_fail++; $display("FAIL b2b_ntrig got %0d want 6", ntrig); end
    for (int i = 1; i < 6; i++) begin
      pop_rec(v1, v2, d);
      n_cmp++; if (v2 !== 1'b1 || d !== ex[i]) begin n_fail++; $display("FAIL b2b_rec%0d got %b/%h want 1/%h", i, v2, d, ex[i]); end
    end
    n_cmp++; if ({empty, count} !== {1'b1, 9'd0}) begin n_fail++; $display("FAIL b2b_drain got %b/%0d want 1/0", empty, count); end
  endtask

  task automatic test_read_mode();
    logic [31:0] t;
    rmode = 1'b1;
    for (int i = 0; i < 10; i++) edge_pulse(16'h0, 16'h0, t);
    rmode = 1'b0;
    tick();
    n_cmp++; if ({count, ntrig, ndrop} !== {9'd0, 32'd6, 16'd0}) begin n_fail++; $display("FAIL rmode_frozen got %0d/%0d/%0d want 0/6/0", count, ntrig, ndrop); end
    edge_pulse(16'h0, 16'h0, t);
    n_cmp++; if ({count, ntrig} !== {9'd1, 32'd7}) begin n_fail++; $display("FAIL rmode_resume got %0d/%0d want 1/7", count, ntrig); end
  endtask

  task automatic test_clear_fetch();
    logic [31:0] t;
    logic v1, v2;
    logic [63:0] d;
    edge_pulse(16'h0, 16'h0, t);
    edge_pulse(16'h0, 16'h0, t);
    n_cmp++; if (count !== 9'd3) begin n_fail++; $display("FAIL clr_pre_count got %0d want 3", count); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    v1 = rd_valid;
    tick();
    n_cmp++; if ({v1, rd_valid} !== 2'b00) begin n_fail++; $display("FAIL clr_no_valid got %b want 00", {v1, rd_valid}); end
    n_cmp++; if ({empty, count, ntrig, ndrop} !== {1'b1, 9'd0, 32'd0, 16'd0}) begin n_fail++; $display("FAIL clr_state got %b/%0d/%0d/%0d want 1/0/0/0", empty, count, ntrig, ndrop); end
    edge_pulse(16'h7777, 16'h8888, t);
    pop_rec(v1, v2, d);
    n_cmp++; if (v2 !== 1'b1 || d !== {t, 16'h7777, 16'h8888}) begin n_fail++; $display("FAIL clr_ts_runs got %b/%h want 1/%h", v2, d, {t, 16'h7777, 16'h8888}); end
  endtask

  task automatic test_ts_wrap();
    logic [34:0] d [2];
    int n = 0;
    while (m_ts[2:0] != 3'd6 && n < 16) begin tick(); n++; end
    w_trig = 1'b1; tick(); w_trig = 1'b0; tick();
    w_trig = 1'b1; tick(); w_trig = 1'b0; tick();
    n_cmp++; if (w_count !== 3'd2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", w_count); end
    for (int i = 0; i < 2; i++) begin
      w_pop = 1'b1; tick(); w_pop = 1'b0; tick();
      d[i] = w_valid ? w_data : 35'h7_FFFF_FFFF;
      tick();
    end
    n_cmp++; if (d[0] !== {3'd6, 16'h0BEE, 16'h0CAD}) begin n_fail++; $display("FAIL wrap_first got %h want %h", d[0], {3'd6, 16'h0BEE, 16'h0CAD}); end
    n_cmp++; if (d[1] !== {3'd0, 16'h0BEE, 16'h0CAD}) begin n_fail++; $display("FAIL wrap_second got %h want %h", d[1], {3'd0, 16'h0BEE, 16'h0CAD}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_read_mode();
    test_clear_fetch();
    test_ts_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
